// File: rtl/wb_pkg.sv
// -----------------------------------------------------------------------------
// wb_pkg
//   Shared types and constants for the register-file write-port arbiter.
//   - XLEN / REG_AW : data width and register-address width
//   - wb_req_t      : one queued long-latency-unit result (rd + data)
//   - wb_gnt_e      : which requester owns the write port this cycle
// -----------------------------------------------------------------------------
package wb_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_req_t;

  typedef enum logic {
    GNT_WB = 1'b0,
    GNT_LU = 1'b1
  } wb_gnt_e;

endpackage

// File: rtl/wb_fifo.sv
// -----------------------------------------------------------------------------
// wb_fifo
//   Small synchronous FIFO holding long-latency-unit results until the
//   register-file write port is free.
//   Ports:
//     clk, rst_n     clock / asynchronous active-low reset (clears all state)
//     push_valid_i   producer offers push_data_i
//     push_ready_o   registered "has space" flag (low during and right at reset)
//     push_data_i    entry to enqueue
//     pop_i          consume the head entry this cycle
//     head_o         current head entry (valid when !empty_o)
//     full_o/empty_o occupancy flags from registered state
// -----------------------------------------------------------------------------
module wb_fifo #(
  parameter int  DEPTH = 2,
  parameter type T     = logic
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push_valid_i,
  output logic push_ready_o,
  input  T     push_data_i,
  input  logic pop_i,
  output T     head_o,
  output logic full_o,
  output logic empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef logic [AW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t DEPTH_C = cnt_t'(DEPTH);

  T     mem_q [DEPTH];
  T     mem_d [DEPTH];
  ptr_t wr_ptr_q, wr_ptr_d;
  ptr_t rd_ptr_q, rd_ptr_d;
  cnt_t count_q, count_d;
  logic ready_q, ready_d;
  logic push_s;
  logic pop_s;

  // Handshake qualification and next-state for pointers, count and storage
  always_comb begin
    push_s   = push_valid_i & ready_q;
    pop_s    = pop_i & (count_q != cnt_t'(0));
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (push_s) begin
      mem_d[wr_ptr_q] = push_data_i;
      wr_ptr_d        = wr_ptr_q + ptr_t'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + ptr_t'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + cnt_t'(1);
      2'b01:   count_d = count_q - cnt_t'(1);
      default: count_d = count_q;
    endcase
    // Ready is computed from next-state occupancy and registered, so a pop of
    // a full FIFO only opens the door on the following cycle.
    ready_d = (count_d != DEPTH_C);
  end

  // FIFO state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ready_q  <= ready_d;
      mem_q    <= mem_d;
    end
  end

  // Status outputs
  always_comb begin
    head_o       = mem_q[rd_ptr_q];
    full_o       = (count_q == DEPTH_C);
    empty_o      = (count_q == cnt_t'(0));
    push_ready_o = ready_q;
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// wb_port_arbiter
//   Shares the single register-file write port between the in-order Writeback
//   stage and a long-latency unit (LU). LU results are queued and drained into
//   idle Writeback cycles; a starvation counter forces a drain by stalling
//   Writeback for exactly one cycle.
//   Ports:
//     clk, rst_n                      clock / async active-low reset
//     wb_we_i, wb_rd_i, wb_data_i     Writeback write request (x0 ignored)
//     wb_stall_o                      hold Writeback this cycle (forced drain)
//     lu_valid_i, lu_ready_o          LU result handshake
//     lu_rd_i, lu_data_i              LU result payload
//     rf_we_o, rf_rd_o, rf_wdata_o    register-file write port
//   XLEN must match wb_pkg::XLEN because queued entries use wb_req_t.
// -----------------------------------------------------------------------------
module wb_port_arbiter #(
  parameter int XLEN       = wb_pkg::XLEN,
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wb_we_i,
  input  logic [wb_pkg::REG_AW-1:0] wb_rd_i,
  input  logic [XLEN-1:0]           wb_data_i,
  output logic                      wb_stall_o,
  input  logic                      lu_valid_i,
  output logic                      lu_ready_o,
  input  logic [wb_pkg::REG_AW-1:0] lu_rd_i,
  input  logic [XLEN-1:0]           lu_data_i,
  output logic                      rf_we_o,
  output logic [wb_pkg::REG_AW-1:0] rf_rd_o,
  output logic [XLEN-1:0]           rf_wdata_o
);

  import wb_pkg::REG_AW;
  import wb_pkg::wb_req_t;
  import wb_pkg::wb_gnt_e;
  import wb_pkg::GNT_WB;
  import wb_pkg::GNT_LU;

  localparam int SW = $clog2(STARVE_MAX + 1);
  typedef logic [SW-1:0] scnt_t;
  localparam scnt_t STARVE_C = scnt_t'(STARVE_MAX);

  wb_req_t lu_entry_s;
  wb_req_t head_s;
  logic    fifo_ready_s;
  logic    fifo_full_s;
  logic    fifo_empty_s;
  logic    fifo_pop_s;
  logic    wb_req_s;
  wb_gnt_e gnt_s;
  logic    gnt_vld_s;
  scnt_t   starve_cnt_q, starve_cnt_d;
  logic    force_q, force_d;

  // Pack the LU result for queuing
  always_comb begin
    lu_entry_s.rd   = lu_rd_i;
    lu_entry_s.data = lu_data_i;
  end

  wb_fifo #(
    .DEPTH (DEPTH),
    .T     (wb_req_t)
  ) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_valid_i (lu_valid_i),
    .push_ready_o (fifo_ready_s),
    .push_data_i  (lu_entry_s),
    .pop_i        (fifo_pop_s),
    .head_o       (head_s),
    .full_o       (fifo_full_s),
    .empty_o      (fifo_empty_s)
  );

  // Grant decision: forced drain, then Writeback, then idle-slot drain
  always_comb begin
    wb_req_s  = wb_we_i & (wb_rd_i != REG_AW'(0));
    gnt_s     = GNT_WB;
    gnt_vld_s = 1'b0;
    if (force_q) begin
      gnt_s     = GNT_LU;
      gnt_vld_s = ~fifo_empty_s;
    end else if (wb_req_s) begin
      gnt_s     = GNT_WB;
      gnt_vld_s = 1'b1;
    end else if (!fifo_empty_s) begin
      gnt_s     = GNT_LU;
      gnt_vld_s = 1'b1;
    end else begin
      gnt_s     = GNT_WB;
      gnt_vld_s = 1'b0;
    end
    // An x0 head is still popped: it consumes the slot without writing.
    fifo_pop_s = gnt_vld_s & (gnt_s == GNT_LU);
  end

  // Starvation counter and forced-drain flag next state
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    force_d      = force_q;
    if (fifo_empty_s || fifo_pop_s) begin
      starve_cnt_d = '0;
      force_d      = 1'b0;
    end else if ((starve_cnt_q + scnt_t'(1)) == STARVE_C) begin
      starve_cnt_d = '0;
      force_d      = 1'b1;
    end else begin
      starve_cnt_d = starve_cnt_q + scnt_t'(1);
      force_d      = force_q;
    end
  end

  // Starvation state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q <= '0;
      force_q      <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      force_q      <= force_d;
    end
  end

  // Write-port mux; everything is held quiet while reset is asserted
  always_comb begin
    rf_we_o    = 1'b0;
    rf_rd_o    = '0;
    rf_wdata_o = '0;
    if (rst_n && gnt_vld_s) begin
      case (gnt_s)
        GNT_WB: begin
          rf_we_o    = 1'b1;
          rf_rd_o    = wb_rd_i;
          rf_wdata_o = wb_data_i;
        end
        GNT_LU: begin
          rf_we_o    = (head_s.rd != REG_AW'(0));
          rf_rd_o    = head_s.rd;
          rf_wdata_o = head_s.data;
        end
        default: begin
          rf_we_o    = 1'b0;
          rf_rd_o    = '0;
          rf_wdata_o = '0;
        end
      endcase
    end else begin
      rf_we_o    = 1'b0;
      rf_rd_o    = '0;
      rf_wdata_o = '0;
    end
    wb_stall_o = rst_n & force_q;
    // The FIFO's registered ready already implies space; the full term keeps
    // the advertised ready honest even if that flag were ever stale.
    lu_ready_o = fifo_ready_s & ~fifo_full_s;
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_port_arbiter
//   Directed bench for wb_port_arbiter (XLEN=32, DEPTH=2, STARVE_MAX=4).
//   Inputs change 1ns after a rising edge; outputs are sampled 3ns after it.
// -----------------------------------------------------------------------------
module tb_wb_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_stall;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_rd;
  logic [31:0] lu_data;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;

  int checks = 0;
  int errors = 0;

  wb_port_arbiter #(
    .XLEN       (32),
    .DEPTH      (2),
    .STARVE_MAX (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wb_we_i    (wb_we),
    .wb_rd_i    (wb_rd),
    .wb_data_i  (wb_data),
    .wb_stall_o (wb_stall),
    .lu_valid_i (lu_valid),
    .lu_ready_o (lu_ready),
    .lu_rd_i    (lu_rd),
    .lu_data_i  (lu_data),
    .rf_we_o    (rf_we),
    .rf_rd_o    (rf_rd),
    .rf_wdata_o (rf_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    rst_n    = 1'b0;
    wb_we    = 1'b1;
    wb_rd    = 5'd5;
    wb_data  = 32'h55;
    lu_valid = 1'b0;
    lu_rd    = 5'd0;
    lu_data  = 32'h0;

    // Reset holds the port quiet even with a live Writeback request
    repeat (2) @(posedge clk);
    #1;
    settle();
    chk("rst_rf_we", rf_we, 1'b0);
    chk("rst_lu_ready", lu_ready, 1'b0);
    chk("rst_stall", wb_stall, 1'b0);

    rst_n = 1'b1;
    wb_we = 1'b0;
    settle();
    chk("rel_ready_same_cycle", lu_ready, 1'b0);
    step();
    settle();
    chk("rel_ready_next_cycle", lu_ready, 1'b1);
    chk("idle_rf_we", rf_we, 1'b0);

    // Idle drain: push at N, write at N+1
    lu_valid = 1'b1;
    lu_rd    = 5'd7;
    lu_data  = 32'hDEADBEEF;
    settle();
    chk("drain_pre_we", rf_we, 1'b0);
    step();
    lu_valid = 1'b0;
    settle();
    chk("drain_we", rf_we, 1'b1);
    chk("drain_rd", rf_rd, 5'd7);
    chk("drain_data", rf_wdata, 32'hDEADBEEF);
    chk("drain_stall", wb_stall, 1'b0);
    step();
    settle();
    chk("drain_empty_we", rf_we, 1'b0);

    // Writeback priority over a queued head, then starvation forces a drain
    lu_valid = 1'b1;
    lu_rd    = 5'd9;
    lu_data  = 32'h99;
    step();
    lu_valid = 1'b0;
    wb_we    = 1'b1;
    wb_rd    = 5'd3;
    wb_data  = 32'h11;
    settle();
    chk("prio_we", rf_we, 1'b1);
    chk("prio_rd", rf_rd, 5'd3);
    chk("prio_data", rf_wdata, 32'h11);
    chk("prio_stall", wb_stall, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      settle();
      chk("starve_wait_stall", wb_stall, 1'b0);
      chk("starve_wait_rd", rf_rd, 5'd3);
    end
    step();
    settle();
    chk("starve_stall", wb_stall, 1'b1);
    chk("starve_we", rf_we, 1'b1);
    chk("starve_rd", rf_rd, 5'd9);
    chk("starve_data", rf_wdata, 32'h99);
    step();
    settle();
    chk("resume_stall", wb_stall, 1'b0);
    chk("resume_rd", rf_rd, 5'd3);
    chk("resume_data", rf_wdata, 32'h11);

    // Back-pressure: fill both entries while Writeback keeps the port busy
    step();
    lu_valid = 1'b1;
    lu_rd    = 5'd10;
    lu_data  = 32'hA0;
    settle();
    chk("fill0_ready", lu_ready, 1'b1);
    step();
    lu_rd   = 5'd11;
    lu_data = 32'hB1;
    settle();
    chk("fill1_ready", lu_ready, 1'b1);
    step();
    lu_rd   = 5'd12;
    lu_data = 32'hC2;
    settle();
    chk("full_ready_a", lu_ready, 1'b0);
    step();
    settle();
    chk("full_ready_b", lu_ready, 1'b0);
    chk("full_stall_b", wb_stall, 1'b0);
    step();
    settle();
    chk("full_ready_c", lu_ready, 1'b0);
    chk("full_stall_c", wb_stall, 1'b0);
    step();
    settle();
    chk("full_force_stall", wb_stall, 1'b1);
    chk("full_force_rd", rf_rd, 5'd10);
    chk("full_force_data", rf_wdata, 32'hA0);
    chk("full_force_no_bypass", lu_ready, 1'b0);
    step();
    settle();
    chk("after_pop_ready", lu_ready, 1'b1);
    chk("after_pop_stall", wb_stall, 1'b0);
    chk("after_pop_wb_rd", rf_rd, 5'd3);
    step();
    lu_valid = 1'b0;
    wb_we    = 1'b0;
    settle();
    chk("refull_ready", lu_ready, 1'b0);
    chk("order_rd_11", rf_rd, 5'd11);
    chk("order_data_11", rf_wdata, 32'hB1);
    step();
    settle();
    chk("order_rd_12", rf_rd, 5'd12);
    chk("order_data_12", rf_wdata, 32'hC2);
    step();
    settle();
    chk("order_empty_we", rf_we, 1'b0);

    // x0 filtering on both sides
    lu_valid = 1'b1;
    lu_rd    = 5'd4;
    lu_data  = 32'h44;
    wb_we    = 1'b1;
    wb_rd    = 5'd0;
    wb_data  = 32'h77;
    settle();
    chk("x0_wb_not_req", rf_we, 1'b0);
    step();
    lu_rd   = 5'd0;
    lu_data = 32'hBAD;
    settle();
    chk("x0_head_we", rf_we, 1'b1);
    chk("x0_head_rd", rf_rd, 5'd4);
    chk("x0_head_data", rf_wdata, 32'h44);
    step();
    lu_valid = 1'b0;
    wb_we    = 1'b0;
    settle();
    chk("x0_lu_entry_we", rf_we, 1'b0);
    chk("x0_lu_entry_stall", wb_stall, 1'b0);
    step();
    wb_we   = 1'b1;
    wb_rd   = 5'd3;
    wb_data = 32'h33;
    // If the x0 entry had stayed queued, starvation would stall Writeback here
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("x0_gone_stall", wb_stall, 1'b0);
      step();
    end

    // Mid-operation reset discards queued LU results
    wb_we    = 1'b0;
    lu_valid = 1'b1;
    lu_rd    = 5'd13;
    lu_data  = 32'hD13;
    step();
    lu_valid = 1'b0;
    rst_n    = 1'b0;
    settle();
    chk("midrst_we", rf_we, 1'b0);
    chk("midrst_ready", lu_ready, 1'b0);
    step();
    rst_n = 1'b1;
    settle();
    chk("midrst_release_we", rf_we, 1'b0);
    step();
    settle();
    chk("midrst_empty_we", rf_we, 1'b0);
    chk("midrst_ready_back", lu_ready, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
